// File: rtl/bus_decoder.sv
// SOL-1 bus address decoder with chip selects and a per-region wait-state FSM.
// Ports: clk, arst (sync, active high), address_bus, mem_io, rd/wr (active low),
//   data_in (config write data); outputs bios_rom_cs, bios_ram_cs, periph_cs
//   (active low, top bit = bios_config), pin_wait (active high), bus_error (pulse).
module bus_decoder #(
    parameter int ADDR_W        = 22,
    parameter int SLOT_W        = 3,
    parameter int WS_W          = 4,
    parameter int ROM_WS_DEF    = 1,
    parameter int RAM_WS_DEF    = 0,
    parameter int PERIPH_WS_DEF = 2
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic [ADDR_W-1:0]      address_bus,
    input  logic                   mem_io,
    input  logic                   rd,
    input  logic                   wr,
    input  logic [7:0]             data_in,
    output logic                   bios_rom_cs,
    output logic                   bios_ram_cs,
    output logic [2**SLOT_W-1:0]   periph_cs,
    output logic                   pin_wait,
    output logic                   bus_error
);

    localparam int N_PERIPH = 2**SLOT_W;
    localparam int N_WS     = 2 + N_PERIPH;
    localparam int CFG_IDX  = N_WS - 1;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t state, state_nxt;

    // Sized to the full 4-bit index space so the address nibble can index it
    // directly; reserved entries are never written and stay at zero.
    logic [WS_W-1:0] ws_tbl [16];

    logic                low_space;
    logic                periph_sp;
    logic                rom_sel;
    logic                ram_sel;
    logic [SLOT_W-1:0]   slot;
    logic [N_PERIPH-1:0] slot_sel;
    logic [3:0]          cur_idx;
    logic                mapped;
    logic [WS_W-1:0]     cur_ws;
    logic                access;
    logic                conflict;
    logic                bad;
    logic                start;
    logic                commit;

    logic                strb_hi_q;
    logic [WS_W-1:0]     cnt;
    logic                lat_cfg_wr;
    logic [3:0]          cfg_idx;
    logic [WS_W-1:0]     cfg_data;
    logic                err_q;

    logic                unused_data;
    assign unused_data = ^data_in[7:WS_W];

    assign low_space = ~|address_bus[ADDR_W-1:16];
    assign periph_sp = mem_io & address_bus[15] & (&address_bus[14:7]);
    assign slot      = address_bus[6 -: SLOT_W];
    assign rom_sel   = mem_io & low_space & ~address_bus[15];
    assign ram_sel   = mem_io & low_space & address_bus[15]
                     & ~(&address_bus[14:7]);

    always_comb begin
        slot_sel = '0;
        if (periph_sp)
            slot_sel[slot] = 1'b1;
    end

    assign bios_rom_cs = ~(rom_sel & ~arst);
    assign bios_ram_cs = ~(ram_sel & ~arst);
    assign periph_cs   = ~(slot_sel & {N_PERIPH{~arst}});

    always_comb begin
        cur_idx = '0;
        mapped  = 1'b0;
        unique case (1'b1)
            rom_sel: begin
                cur_idx = 4'd0;
                mapped  = 1'b1;
            end
            ram_sel: begin
                cur_idx = 4'd1;
                mapped  = 1'b1;
            end
            periph_sp: begin
                cur_idx = 4'd2 + 4'(slot);
                mapped  = 1'b1;
            end
            default: begin
                cur_idx = '0;
                mapped  = 1'b0;
            end
        endcase
    end

    assign cur_ws   = mapped ? ws_tbl[cur_idx] : '0;
    assign access   = ~rd | ~wr;
    assign conflict = ~rd & ~wr;
    // With mem_io low nothing is decoded, which is a quiet no-op, not an error.
    assign bad      = mem_io & (~mapped | conflict);
    assign start    = ~arst & (state == IDLE) & access & strb_hi_q;
    assign commit   = (state == HOLD) & ~access & lat_cfg_wr;

    assign pin_wait = ~arst
                    & ((start & ~bad & (cur_ws != '0)) | (state == WAIT));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nxt = (bad || cur_ws == '0) ? HOLD : WAIT;
            end
            WAIT: begin
                if (!access)
                    state_nxt = IDLE;
                else if (cnt == '0)
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (!access)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state      <= IDLE;
            strb_hi_q  <= 1'b0;
            cnt        <= '0;
            lat_cfg_wr <= 1'b0;
            cfg_idx    <= '0;
            cfg_data   <= '0;
            err_q      <= 1'b0;
            bus_error  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                if (i == 0)
                    ws_tbl[i] <= WS_W'(ROM_WS_DEF);
                else if (i == 1)
                    ws_tbl[i] <= WS_W'(RAM_WS_DEF);
                else if (i < N_WS)
                    ws_tbl[i] <= WS_W'(PERIPH_WS_DEF);
                else
                    ws_tbl[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            strb_hi_q <= rd & wr;
            // Two-stage so the error pulse lands one cycle after start.
            err_q     <= start & bad;
            bus_error <= err_q;

            if (start) begin
                cnt        <= cur_ws - 1'b1;
                lat_cfg_wr <= ~bad & ~wr & (cur_idx == 4'(CFG_IDX));
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            // Track the latest write data; only the value present when
            // the access ends in HOLD is committed.
            if (!wr && (start || state == WAIT || state == HOLD)) begin
                cfg_idx  <= address_bus[3:0];
                cfg_data <= data_in[WS_W-1:0];
            end

            if (commit && int'(cfg_idx) < N_WS)
                ws_tbl[cfg_idx] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_bus_decoder.sv
// Testbench for bus_decoder: decode vector table plus access scoreboard.
// Samples outputs 1 time unit after each rising edge.
module tb_bus_decoder;

    logic        clk = 1'b0;
    logic        arst;
    logic [21:0] address_bus;
    logic        mem_io;
    logic        rd;
    logic        wr;
    logic [7:0]  data_in;
    logic        bios_rom_cs;
    logic        bios_ram_cs;
    logic [7:0]  periph_cs;
    logic        pin_wait;
    logic        bus_error;
    logic [9:0]  cs_v;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign cs_v = {bios_rom_cs, bios_ram_cs, periph_cs};

    bus_decoder dut (
        .clk         (clk),
        .arst        (arst),
        .address_bus (address_bus),
        .mem_io      (mem_io),
        .rd          (rd),
        .wr          (wr),
        .data_in     (data_in),
        .bios_rom_cs (bios_rom_cs),
        .bios_ram_cs (bios_ram_cs),
        .periph_cs   (periph_cs),
        .pin_wait    (pin_wait),
        .bus_error   (bus_error)
    );

    localparam logic [9:0] CS_NONE = 10'b1_1_11111111;
    localparam logic [9:0] CS_ROM  = 10'b0_1_11111111;
    localparam logic [9:0] CS_RAM  = 10'b1_0_11111111;
    localparam logic [9:0] CS_S0   = 10'b1_1_11111110;
    localparam logic [9:0] CS_S2   = 10'b1_1_11111011;
    localparam logic [9:0] CS_S5   = 10'b1_1_11011111;
    localparam logic [9:0] CS_CFG  = 10'b1_1_01111111;

    typedef struct {
        string       nm;
        logic [9:0]  cs;
        logic [31:0] wmask;
        logic [31:0] emask;
    } exp_t;

    typedef struct {
        logic [21:0] a;
        logic        mio;
        logic [9:0]  cs;
    } dvec_t;

    exp_t  sb[$];
    dvec_t dv[11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // One complete access: strobe held 18 cycles, then released.
    task automatic access(input string nm, input logic [21:0] a,
                          input logic mio, input logic r, input logic w,
                          input logic [7:0] d, input logic [9:0] cs_e,
                          input int ws, input logic err);
        exp_t e;
        logic [9:0]  g_cs;
        logic [31:0] g_w;
        logic [31:0] g_e;
        e.nm    = nm;
        e.cs    = cs_e;
        e.wmask = (32'd1 << ws) - 32'd1;
        e.emask = err ? 32'd2 : 32'd0;
        sb.push_back(e);
        g_cs = '1;
        g_w  = '0;
        g_e  = '0;
        @(negedge clk);
        address_bus = a;
        mem_io      = mio;
        rd          = r;
        wr          = w;
        data_in     = d;
        for (int k = 0; k < 18; k++) begin
            @(posedge clk);
            #1;
            if (k == 0)
                g_cs = cs_v;
            g_w[k] = pin_wait;
            g_e[k] = bus_error;
        end
        @(negedge clk);
        rd = 1'b1;
        wr = 1'b1;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.nm, "/cs"}, 32'(g_cs), 32'(e.cs));
        chk({e.nm, "/wait"}, g_w, e.wmask);
        chk({e.nm, "/err"}, g_e, e.emask);
        chk({e.nm, "/rel"}, 32'(pin_wait), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] wm;
        exp_t e;

        dv[0]  = '{22'h000100, 1'b1, CS_ROM};
        dv[1]  = '{22'h008000, 1'b1, CS_RAM};
        dv[2]  = '{22'h00FFA0, 1'b1, CS_S2};
        dv[3]  = '{22'h00FF80, 1'b1, CS_S0};
        dv[4]  = '{22'h00FFF0, 1'b1, CS_CFG};
        dv[5]  = '{22'h00FF7F, 1'b1, CS_RAM};
        dv[6]  = '{22'h100000, 1'b1, CS_NONE};
        dv[7]  = '{22'h000100, 1'b0, CS_NONE};
        dv[8]  = '{22'h010000, 1'b1, CS_NONE};
        dv[9]  = '{22'h007FFF, 1'b1, CS_ROM};
        dv[10] = '{22'h00FFD5, 1'b1, CS_S5};

        arst        = 1'b1;
        address_bus = '0;
        mem_io      = 1'b1;
        rd          = 1'b1;
        wr          = 1'b1;
        data_in     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/cs", 32'(cs_v), 32'(CS_NONE));
        chk("rst/wait", 32'(pin_wait), 32'd0);
        chk("rst/err", 32'(bus_error), 32'd0);
        @(negedge clk);
        arst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            address_bus = dv[i].a;
            mem_io      = dv[i].mio;
            e.nm        = $sformatf("dec%0d", i);
            e.cs        = dv[i].cs;
            sb.push_back(e);
            #2;
            e = sb.pop_front();
            chk(e.nm, 32'(cs_v), 32'(e.cs));
        end

        access("rom", 22'h000100, 1, 0, 1, 8'h00, CS_ROM, 1, 0);
        access("ram", 22'h008000, 1, 0, 1, 8'h00, CS_RAM, 0, 0);
        access("s2", 22'h00FFA0, 1, 0, 1, 8'h00, CS_S2, 2, 0);
        access("cfg5", 22'h00FFF0, 1, 1, 0, 8'h05, CS_CFG, 2, 0);
        access("rom5", 22'h000000, 1, 0, 1, 8'h00, CS_ROM, 5, 0);
        access("cfg1", 22'h00FFF0, 1, 1, 0, 8'h01, CS_CFG, 2, 0);
        access("cfgres", 22'h00FFFC, 1, 1, 0, 8'h0F, CS_CFG, 2, 0);
        access("rom1", 22'h000000, 1, 0, 1, 8'h00, CS_ROM, 1, 0);
        access("s0", 22'h00FF80, 1, 0, 1, 8'h00, CS_S0, 2, 0);
        access("unmap", 22'h100000, 1, 0, 1, 8'h00, CS_NONE, 0, 1);
        access("conf", 22'h000000, 1, 0, 0, 8'h07, CS_ROM, 0, 1);
        access("confcfg", 22'h00FFF0, 1, 0, 0, 8'h07, CS_CFG, 0, 1);
        access("rom1b", 22'h000000, 1, 0, 1, 8'h00, CS_ROM, 1, 0);
        access("noio", 22'h000000, 0, 0, 1, 8'h00, CS_NONE, 0, 0);

        // Address moves to ROM mid-access; latched slot count still rules.
        wm = '0;
        @(negedge clk);
        address_bus = 22'h00FFA0;
        mem_io      = 1'b1;
        rd          = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            wm[k] = pin_wait;
            if (k == 0)
                address_bus = 22'h000000;
            if (k == 1)
                chk("mid/cs", 32'(cs_v), 32'(CS_ROM));
        end
        chk("mid/wait", wm, 32'h3);
        @(negedge clk);
        rd = 1'b1;

        // RAM to 4 wait states, then release the strobe early.
        access("cfgram", 22'h00FFF1, 1, 1, 0, 8'h04, CS_CFG, 2, 0);
        @(negedge clk);
        address_bus = 22'h008000;
        rd          = 1'b0;
        @(posedge clk);
        #1;
        chk("early/w0", 32'(pin_wait), 32'd1);
        @(posedge clk);
        #1;
        chk("early/w1", 32'(pin_wait), 32'd1);
        @(negedge clk);
        rd = 1'b1;
        @(posedge clk);
        #1;
        chk("early/rel", 32'(pin_wait), 32'd0);
        access("ram4", 22'h008000, 1, 0, 1, 8'h00, CS_RAM, 4, 0);

        // ROM at the maximum count, reset lands in cycle 4 of the stall.
        access("cfg15", 22'h00FFF0, 1, 1, 0, 8'h0F, CS_CFG, 2, 0);
        wm = '0;
        @(negedge clk);
        address_bus = 22'h000000;
        rd          = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            wm[k] = pin_wait;
        end
        chk("r15/wait", wm, 32'hF);
        @(negedge clk);
        arst = 1'b1;
        @(posedge clk);
        #1;
        chk("r15/wait_rst", 32'(pin_wait), 32'd0);
        chk("r15/err_rst", 32'(bus_error), 32'd0);
        chk("r15/cs_rst", 32'(cs_v), 32'(CS_NONE));
        @(negedge clk);
        arst = 1'b0;
        rd   = 1'b1;
        @(posedge clk);
        #1;
        chk("r15/idle", 32'(pin_wait), 32'd0);
        access("romdef", 22'h000000, 1, 0, 1, 8'h00, CS_ROM, 1, 0);
        access("ramdef", 22'h008000, 1, 0, 1, 8'h00, CS_RAM, 0, 0);

        // Reset while a config write sits in HOLD drops the pending write.
        @(negedge clk);
        address_bus = 22'h00FFF0;
        data_in     = 8'h09;
        wr          = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        wr   = 1'b1;
        access("rompend", 22'h000000, 1, 0, 1, 8'h00, CS_ROM, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_decoder.md
# bus_decoder

Parametrised address decoder and wait-state generator for the SOL-1 system bus. It produces active-low chip selects for BIOS ROM, BIOS RAM and 2**SLOT_W peripheral slots from the CPU address bus. A small per-region state machine drives `pin_wait` to stretch slow accesses. Wait-state counts are held in a software-writable table that lives in the bios_config slot, so firmware can retune timing per region at run time.

## Interface

Parameters:
- ADDR_W, 22, address bus width; must be ≥ 17.
- SLOT_W, 3, peripheral slot select width; N_PERIPH = 2**SLOT_W; 1 ≤ SLOT_W ≤ 3.
- WS_W, 4, wait-state counter width; maximum wait count is 2**WS_W-1.
- ROM_WS_DEF, 1, ROM wait states loaded at reset.
- RAM_WS_DEF, 0, RAM wait states loaded at reset.
- PERIPH_WS_DEF, 2, wait states loaded at reset into every peripheral slot.

Ports:
- clk, in, 1, system clock; all state changes on its rising edge.
- arst, in, 1, reset, synchronous and active-high.
- address_bus, in, ADDR_W, CPU address.
- mem_io, in, 1, high = decoded space; low = no decode.
- rd, in, 1, read strobe, active low.
- wr, in, 1, write strobe, active low.
- data_in, in, 8, CPU write data.
- bios_rom_cs, out, 1, ROM select, active low.
- bios_ram_cs, out, 1, RAM select, active low.
- periph_cs, out, N_PERIPH, peripheral slot selects, active low; bit N_PERIPH-1 is bios_config.
- pin_wait, out, 1, wait request to CPU, active high.
- bus_error, out, 1, one-cycle pulse on an illegal access.

## Operation

Decode is combinational. All selects are forced high while `arst`=1.
- real = ~|address_bus[ADDR_W-1:16].
- periph = mem_io & address_bus[15] & (&address_bus[14:7]).
- ROM is selected when mem_io & real & !a15.
- RAM is selected when mem_io & real & a15 & !(&a[14:7]).
- Slot k is selected when periph & (address_bus[6:4] >> (3-SLOT_W)) == k. The slot index is taken from the top SLOT_W bits of a[6:4].
- When mem_io=0, no select is active and there is no wait and no error.

An access is "unmapped" when mem_io=1 and no select is active (for example a[21:16]≠0). An access is "conflict" when rd=0 and wr=0 together.

Wait table: WS registers of WS_W bits each.
- Index 0 = ROM.
- Index 1 = RAM.
- Index 2+k = slot k.
- Index 2+N_PERIPH through 15 are reserved. Writes to them are ignored.

Config write: a wr access to slot N_PERIPH-1 targets the table entry at index address_bus[3:0]. It writes data_in[WS_W-1:0] into that entry.

State machine: IDLE, WAIT, HOLD.
- IDLE → start when (rd=0 or wr=0) is sampled after both strobes were high. The region is latched at start.
  - Unmapped or conflict: pulse bus_error, go to HOLD, no wait.
  - Latched ws = 0: go to HOLD.
  - Latched ws > 0: load counter = ws-1, go to WAIT.
- WAIT: the counter decrements each cycle. When counter = 0 is reached and the strobe is still low, go to HOLD. If the strobe goes high early, go to IDLE.
- HOLD: stay until rd=1 and wr=1 are sampled, then go to IDLE.
- Config commit: data_in and the index are registered on every cycle with wr=0 in WAIT or HOLD. The write commits on the HOLD→IDLE edge, using the last registered value. The write is aborted if the access was a conflict.

## Timing

Cycle 0 is the first rising edge at which a strobe is sampled low.
- pin_wait is combinational: (IDLE & start & ws≠0) | WAIT. It is high for cycles 0..ws-1 and low from cycle ws on.
- bus_error is registered. It is high for exactly cycle 1.
- A new ws value takes effect on the next access start; an in-flight access keeps its latched count.
- ws = 2**WS_W-1 gives the maximum stall; there is no counter wrap.
- Address changes mid-access do not change the latched region. Chip selects still follow the address combinationally.

Reset values (applied on the first clock edge with arst=1, even mid-access):
- state = IDLE.
- pin_wait = 0.
- bus_error = 0.
- selects high.
- table = defaults.
- pending commit discarded.

## Test plan

- Reset, then read 0x000100 with mem_io=1 → bios_rom_cs=0 and pin_wait high for exactly 1 cycle; then read 0x008000 → bios_ram_cs=0 and no pin_wait.
- Read 0x00FFA0 (slot 2) → periph_cs=8'b11111011 and pin_wait high for 2 cycles.
- Write 0x05 to 0x00FFF0 (config index 0), release wr, then read 0x000000 → ROM pin_wait high for 5 cycles.
- Write to 0x00FFFC (index 12, reserved) → table unchanged; a following ROM read still stalls 1 cycle.
- Read 0x100000 with mem_io=1 → all selects high, bus_error=1 for one cycle, no pin_wait; then rd=0 and wr=0 at 0x000000 → bus_error pulse and no table write.
- Config ROM ws = 15, start a read, assert arst in cycle 3 → on the next edge pin_wait=0, state IDLE, ROM ws back to 1.
